// File: rtl/mux_sel_scheduler_if.sv
// Handshake bundle between the request sources, the select scheduler and the 4:1 mux.
// The lock line exists only when MUX_SEL_LOCK_EN is defined.
interface mux_sel_scheduler_if;
  logic       en;
  logic [3:0] req;
`ifdef MUX_SEL_LOCK_EN
  logic       lock;
`endif
  logic       s1;
  logic       s2;
  logic [3:0] gnt;
  logic       valid;

`ifdef MUX_SEL_LOCK_EN
  modport master (output en, output req, output lock,
                  input s1, input s2, input gnt, input valid);
  modport slave  (input en, input req, input lock,
                  output s1, output s2, output gnt, output valid);
`else
  modport master (output en, output req,
                  input s1, input s2, input gnt, input valid);
  modport slave  (input en, input req,
                  output s1, output s2, output gnt, output valid);
`endif
endinterface

// File: rtl/mux_sel_scheduler.sv
// Round-robin select generator for a 4:1 mux with a programmable dwell per grant.
// Optional feature macro: MUX_SEL_LOCK_EN (adds a lock input that suspends dwell expiry).
module mux_sel_scheduler #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_sel_scheduler_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int unsigned   DWELL_EFF = (DWELL == 0) ? 1 : DWELL;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(DWELL_EFF - 1);

  if (DWELL > ((2 ** CW) - 1)) begin : g_dwell_range_err
    $error("mux_sel_scheduler: DWELL=%0d does not fit in CW=%0d bits", DWELL, CW);
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    last_q,  last_d;
  logic [1:0]    sel_q,   sel_d;
  logic [3:0]    gnt_q,   gnt_d;
  logic          valid_q, valid_d;

  logic          win_found_s;
  logic [1:0]    win_idx_s;
  logic          lock_s;
  logic          expired_s;
  logic          release_s;

  // Circular search from last+1; descending order lets the nearest hit overwrite,
  // so the current holder (offset 4) is the final candidate.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef MUX_SEL_LOCK_EN
  assign lock_s = bus.lock;
`else
  assign lock_s = 1'b0;
`endif

  assign {win_found_s, win_idx_s} = rr_pick(bus.req, last_q);
  assign expired_s = (cnt_q == {CW{1'b0}}) && !lock_s;
  assign release_s = expired_s || !bus.req[last_q] || !bus.en;

  // State and output registers; reset restarts the search at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: grant on any search hit, hold while dwelling, else go idle keeping selects.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.en && win_found_s) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
          last_d  = win_idx_s;
          sel_d   = win_idx_s;
          gnt_d   = 4'b0001 << win_idx_s;
          valid_d = 1'b1;
        end else begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (release_s) begin
          if (bus.en && win_found_s) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
            last_d  = win_idx_s;
            sel_d   = win_idx_s;
            gnt_d   = 4'b0001 << win_idx_s;
            valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else begin
          // Under lock the counter parks at zero rather than wrapping.
          if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.s1    = sel_q[1];
  assign bus.s2    = sel_q[0];
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench for mux_sel_scheduler (DWELL=4); lock steps run when MUX_SEL_LOCK_EN is defined.
module tb_mux_sel_scheduler;
  logic clk;
  logic rst;
  int   n_err;
  int   n_checks;

  mux_sel_scheduler_if bus ();

  mux_sel_scheduler #(.DWELL(4), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp is {valid, s1, s2, gnt[3:0]}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {bus.valid, bus.s1, bus.s2, bus.gnt};
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] busy(input int ch);
    logic [1:0] idx;
    idx = 2'(ch);
    return {1'b1, idx, 4'b0001 << idx};
  endfunction

  initial begin
    n_err    = 0;
    n_checks = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.req  = 4'b1111;
`ifdef MUX_SEL_LOCK_EN
    bus.lock = 1'b0;
`endif

    step(); chk("reset_c1", 7'b0000000);
    bus.en = 1'b1;
    step(); chk("reset_c2", 7'b0000000);
    rst = 1'b0;

    step(); chk("first_grant", busy(0));
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        if (!(g == 0 && k == 0)) begin
          step();
        end
        chk($sformatf("rotate_g%0d_k%0d", g, k), busy(g % 4));
      end
    end

    bus.req = 4'b0101;
    step(); chk("rr_skip_to_ch2", busy(2));
    step(); step(); step();
    chk("ch2_dwell_end", busy(2));
    step(); chk("ch0_grant", busy(0));
    step(); chk("ch0_hold", busy(0));
    bus.req = 4'b0100;
    step(); chk("early_drop_b2b", busy(2));

    bus.req = 4'b0000;
    step(); chk("idle_hold_sel", 7'b0100000);
    step(); chk("idle_hold_sel2", 7'b0100000);

    bus.req = 4'b0010;
    step(); chk("grant_ch1", busy(1));
    bus.en  = 1'b0;
    bus.req = 4'b1111;
    step(); chk("en_low_release", 7'b0010000);
    step(); chk("en_low_blocks", 7'b0010000);
    bus.en = 1'b1;
    step(); chk("en_resume_ch2", busy(2));
    step();
    rst = 1'b1;
    step(); chk("rst_mid_dwell", 7'b0000000);
    rst = 1'b0;
    step(); chk("post_rst_ch0", busy(0));

    bus.req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step(); chk($sformatf("lone_req_k%0d", k), busy(0));
    end

`ifdef MUX_SEL_LOCK_EN
    bus.req  = 4'b0011;
    bus.lock = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(); chk($sformatf("lock_hold_k%0d", k), busy(0));
    end
    bus.lock = 1'b0;
    step(); chk("lock_release", busy(1));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
